ksa_sum_stage: RTL and testbench
================================

# ksa_sum_stage

Output end of the 32-bit Kogge-Stone adder. It takes the bitwise propagate vector from the g/p generation stage and the final group-generate (carry) vector from the last prefix stage. It forms the sum, carry-out, signed-overflow and zero flags, and registers them behind a valid/ready handshake with a two-entry skid buffer. This lets the adder pipeline stall without dropping results.

## Interface
- WIDTH, 32: operand width; all vectors are WIDTH bits.

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream presents p/G/cin this cycle
- in_ready  output  1  stage can accept; registered, depends only on skid occupancy
- p  input  WIDTH  bitwise propagate, p[i] = a[i] ^ b[i]
- G  input  WIDTH  group generate; G[i] = carry out of bit i, including the cin contribution
- cin  input  1  carry into bit 0
- out_valid  output  1  sum/flags are valid
- out_ready  input  1  downstream accepts this cycle
- sum  output  WIDTH  result
- cout  output  1  carry out of the MSB
- ovf  output  1  two's-complement overflow
- zero  output  1  sum == 0

## Operation
- Carry vector: c[0] = cin; c[i] = G[i-1] for i = 1..WIDTH-1.
- sum = p ^ c, where c is {G[WIDTH-2:0], cin}.
- cout = G[WIDTH-1].
- ovf = G[WIDTH-2] ^ G[WIDTH-1].
- zero = (sum == 0).
- All results are computed combinationally from inputs and captured as one record {sum, cout, ovf, zero} of WIDTH+3 bits.
- Storage is an output register (OR) and a skid register (SK).
- The FSM has three states:
  - EMPTY: OR and SK invalid.
  - ONE: OR valid, SK invalid.
  - TWO: OR valid, SK valid.
- Define acc = in_valid & in_ready and pop = out_valid & out_ready.
- Transitions:
  - EMPTY: acc → OR ← new, go to ONE.
  - ONE: acc & !pop → SK ← new, go to TWO.
  - ONE: acc & pop → OR ← new, stay in ONE.
  - ONE: !acc & pop → go to EMPTY.
  - TWO: pop → OR ← SK, go to ONE. No acc is possible, since in_ready = 0.
  - All other cases hold the current state.
- out_valid = (state != EMPTY).
- in_ready = (state != TWO), registered: it equals 1 in the cycle after reset and after any transition out of TWO.
- Results leave the stage in acceptance order. None is dropped or duplicated.
- Inputs are sampled only when acc = 1. When in_valid = 0, p/G/cin are don't-care.

## Timing
- Reset (rst_n low, asynchronous) sets:
  - state = EMPTY, out_valid = 0.
  - in_ready = 1 on deassertion. It is held 0 while rst_n is low.
  - sum = 0, cout = 0, ovf = 0, zero = 0.
  - SK contents are cleared.
- Reset mid-operation discards every held record. No output is produced from pre-reset data.
- Latency: a record accepted on edge N is visible on the outputs after edge N (out_valid = 1 in cycle N+1) when OR was empty or popping.
- Throughput: one result per cycle while out_ready = 1.
- Backpressure: with out_ready = 0, two records are accepted, then in_ready falls the cycle after the second acceptance. No acceptance occurs while in_ready = 0.
- Output stability: while out_valid = 1 and out_ready = 0, sum/cout/ovf/zero hold constant.
- Simultaneous pop and accept in ONE replaces OR in the same edge with no bubble.
- Simultaneous pop in TWO with in_valid = 1: only the pop happens. in_ready becomes 1 next cycle.

## Test plan
- Reset check: assert rst_n low mid-stream with TWO occupied → out_valid = 0 and sum = 0 immediately; after release, in_ready = 1, out_valid = 0.
- Zero and carry: a = 0xFFFFFFFF, b = 0x00000001, cin = 0 (p = 0xFFFFFFFE, G = 0xFFFFFFFF), out_ready = 1 → next cycle sum = 0x00000000, cout = 1, ovf = 0, zero = 1.
- Overflow: a = 0x7FFFFFFF, b = 0x00000001, cin = 0 (p = 0x7FFFFFFE, G = 0x7FFFFFFF) → sum = 0x80000000, cout = 0, ovf = 1, zero = 0.
- cin path: p = 0x00000000, G = 0x00000000, cin = 1 → sum = 0x00000001, cout = 0, zero = 0.
- Backpressure: stream records R0..R4 with out_ready = 0 → R0 and R1 accepted, in_ready = 0 from the third cycle, outputs frozen on R0. Then raise out_ready → outputs R0, R1, R2, R3, R4 in order, with no loss or duplicates.
- Random soak: 10k random a/b/cin, with the golden model deriving p/G, plus random in_valid/out_ready → every sum equals a + b + cin mod 2^32, flags match, and order is preserved.

Source files
------------

// File: rtl/ksa_sum_stage.sv
// Kogge-Stone adder output stage: forms sum/cout/ovf/zero from p and the final
// group-generate vector, then holds results in a two-entry skid buffer behind valid/ready.
module ksa_sum_stage #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] p,
  input  logic [WIDTH-1:0] G,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned RW = WIDTH + 3;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_TWO
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_in_ready;
  logic [RW-1:0]   r_or;
  logic [RW-1:0]   r_sk;
  logic [RW-1:0]   w_new;
  logic [WIDTH-1:0] w_c;
  logic [WIDTH-1:0] w_sum;
  logic            w_acc;
  logic            w_pop;
  logic            w_ld_or_new;
  logic            w_ld_or_sk;
  logic            w_ld_sk;

  // Carry into bit i is the group generate of bits [i-1:0]; overflow compares carries into/out of the MSB.
  assign w_c   = {G[WIDTH-2:0], cin};
  assign w_sum = p ^ w_c;
  assign w_new = {w_sum, G[WIDTH-1], G[WIDTH-2] ^ G[WIDTH-1], (w_sum == '0)};

  assign w_acc = in_valid & in_ready;
  assign w_pop = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
      r_or       <= '0;
      r_sk       <= '0;
    end else begin
      r_state    <= w_next;
      r_in_ready <= (w_next != ST_TWO);
      if (w_ld_or_new) begin
        r_or <= w_new;
      end else if (w_ld_or_sk) begin
        r_or <= r_sk;
      end
      if (w_ld_sk) begin
        r_sk <= w_new;
      end
    end
  end

  always_comb begin
    w_next      = r_state;
    w_ld_or_new = 1'b0;
    w_ld_or_sk  = 1'b0;
    w_ld_sk     = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_acc) begin
          w_ld_or_new = 1'b1;
          w_next      = ST_ONE;
        end
      end
      ST_ONE: begin
        if (w_acc && !w_pop) begin
          w_ld_sk = 1'b1;
          w_next  = ST_TWO;
        end else if (w_acc && w_pop) begin
          w_ld_or_new = 1'b1;
        end else if (w_pop) begin
          w_next = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (w_pop) begin
          w_ld_or_sk = 1'b1;
          w_next     = ST_ONE;
        end
      end
      default: w_next = ST_EMPTY;
    endcase
  end

  // Ready flop resets to 1; gating with rst_n keeps it low only while reset is held.
  always_comb begin
    out_valid              = (r_state != ST_EMPTY);
    in_ready               = rst_n & r_in_ready;
    {sum, cout, ovf, zero} = r_or;
  end

endmodule

// File: tb/tb_ksa_sum_stage.sv
// Self-checking bench for ksa_sum_stage: table vectors, backpressure and reset
// sequences, and a random soak, all checked through an in-order scoreboard.
module tb_ksa_sum_stage;

  localparam int unsigned W = 32;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  p;
  logic [W-1:0]  G;
  logic          cin;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  sum;
  logic          cout;
  logic          ovf;
  logic          zero;

  ksa_sum_stage #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .p         (p),
    .G         (G),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic [W-1:0] e_sum;
    logic         e_cout;
    logic         e_ovf;
    logic         e_zero;
  } vec_t;

  int n_pass  = 0;
  int n_total = 0;
  logic [W+2:0] q[$];
  logic [W+2:0] cur_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [W-1:0] gen_g(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    logic [W-1:0] g;
    logic c;
    c = ci;
    for (int unsigned i = 0; i < W; i++) begin
      g[i] = (a[i] & b[i]) | ((a[i] ^ b[i]) & c);
      c    = g[i];
    end
    return g;
  endfunction

  function automatic logic [W+2:0] golden(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    logic [W:0]   s;
    logic [W-1:0] r;
    logic         v;
    s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    r = s[W-1:0];
    v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
    return {r, s[W], v, (r == '0)};
  endfunction

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    p       = a ^ b;
    G       = gen_g(a, b, ci);
    cin     = ci;
    cur_exp = golden(a, b, ci);
  endtask

  // Decide at the falling edge what the next rising edge will pop/accept.
  task automatic step(output bit acc);
    logic [W+2:0] e;
    @(negedge clk);
    if (out_valid && out_ready) begin
      check("sb_pending", (q.size() > 0), 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("out_record", {sum, cout, ovf, zero}, e);
      end
    end
    acc = in_valid && in_ready;
    if (acc) q.push_back(cur_exp);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit acc;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8 && q.size() > 0; i++) step(acc);
    check("drain_empty", q.size(), 0);
  endtask

  vec_t         tbl[9];
  logic [W+2:0] bp_exp[5];
  logic [W-1:0] bp_a[5];
  logic [W-1:0] bp_b[5];

  initial begin
    bit acc;
    int idx;
    int accepted;
    int cyc;

    tbl[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    tbl[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
    tbl[4] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    tbl[8] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    p = '0; G = '0; cin = 1'b0; cur_exp = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_outputs", {sum, cout, ovf, zero}, 0);
    check("rst_in_ready_held", in_ready, 0);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready", in_ready, 1);
    check("rel_out_valid", out_valid, 0);

    // Table vectors: one record per cycle with the sink always ready.
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].a, tbl[i].b, tbl[i].ci);
      cur_exp  = {tbl[i].e_sum, tbl[i].e_cout, tbl[i].e_ovf, tbl[i].e_zero};
      in_valid = 1'b1;
      step(acc);
      check("tbl_accept", acc, 1);
    end
    drain();

    // Backpressure: sink stalled, two accepts then ready drops and OR holds R0.
    for (int i = 0; i < 5; i++) begin
      bp_a[i]   = $urandom();
      bp_b[i]   = $urandom();
      bp_exp[i] = golden(bp_a[i], bp_b[i], 1'b0);
    end
    out_ready = 1'b0;
    idx = 0;
    drive(bp_a[0], bp_b[0], 1'b0);
    in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      check("bp_in_ready", in_ready, (k < 2) ? 1 : 0);
      if (k >= 1) check("bp_hold_r0", {out_valid, sum, cout, ovf, zero}, {1'b1, bp_exp[0]});
      step(acc);
      if (acc) begin
        idx++;
        drive(bp_a[idx], bp_b[idx], 1'b0);
      end
    end
    check("bp_accepted", idx, 2);
    out_ready = 1'b1;
    for (int k = 0; k < 20 && idx < 5; k++) begin
      step(acc);
      if (acc) begin
        idx++;
        if (idx < 5) drive(bp_a[idx], bp_b[idx], 1'b0);
        else in_valid = 1'b0;
      end
    end
    check("bp_all_accepted", idx, 5);
    drain();

    // Reset with both entries occupied: everything held must vanish.
    out_ready = 1'b0;
    drive(32'h0000_1111, 32'h0000_2222, 1'b0);
    in_valid = 1'b1;
    step(acc);
    drive(32'h0000_3333, 32'h0000_4444, 1'b1);
    step(acc);
    in_valid = 1'b0;
    check("pre_rst_full", in_ready, 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_sum", sum, 0);
    q.delete();
    #1;
    rst_n = 1'b1;
    #1;
    check("mid_rel_in_ready", in_ready, 1);
    check("mid_rel_out_valid", out_valid, 0);
    out_ready = 1'b1;
    repeat (3) step(acc);
    check("post_rst_no_output", out_valid, 0);

    // Random soak with random valid/ready.
    accepted = 0;
    cyc = 0;
    drive($urandom(), $urandom(), 1'($urandom_range(0, 1)));
    in_valid = 1'b1;
    while (accepted < 10000 && cyc < 40000) begin
      step(acc);
      cyc++;
      if (acc) begin
        accepted++;
        drive($urandom(), $urandom(), 1'($urandom_range(0, 1)));
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
    end
    check("soak_accepted", accepted, 10000);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
